// File: rtl/pbvi_iter_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pbvi_iter_ctrl: sequences backup stages 1-2-3 per value-iteration step.  |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module pbvi_iter_ctrl #(
    parameter int TIMEOUT = 64,
    parameter int ITER_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ITER_W-1:0] num_iter,
    input  logic              abort,
    input  logic              done1,
    input  logic              done2,
    input  logic              done3,
    input  logic              converged,
    output logic              en_step1,
    output logic              en_step2,
    output logic              en_step3,
    output logic              busy,
    output logic              done,
    output logic [ITER_W-1:0] iter_cnt,
    output logic              err_timeout,
    output logic              conv_hit,
    output logic [1:0]        stage
);

    localparam int                c_WD_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [c_WD_W-1:0] c_WD_MAX = c_WD_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_K1   = 3'd1,
        S_W1   = 3'd2,
        S_K2   = 3'd3,
        S_W2   = 3'd4,
        S_K3   = 3'd5,
        S_W3   = 3'd6,
        S_FIN  = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_nxt;
    logic [1:0]        w_stage_nxt;
    logic [c_WD_W-1:0] r_wd;
    logic [ITER_W-1:0] r_num;
    logic [ITER_W-1:0] r_iter;
    logic [ITER_W-1:0] w_iter_inc;
    logic              w_wait;
    logic              w_tmo;
    logic              w_acc3;
    logic              w_set_tmo;
    logic              w_take_start;

    assign w_iter_inc   = r_iter + ITER_W'(1);
    assign w_wait       = (r_state == S_W1) || (r_state == S_W2) || (r_state == S_W3);
    assign w_tmo        = w_wait && (r_wd == c_WD_MAX);
    assign w_take_start = (r_state == S_IDLE) && start;
    assign iter_cnt     = r_iter;

    always_comb begin
        w_nxt     = r_state;
        w_acc3    = 1'b0;
        w_set_tmo = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_nxt = (num_iter == '0) ? S_FIN : S_K1;
            S_K1:   w_nxt = S_W1;
            S_W1: begin
                if (done1) begin
                    w_nxt = S_K2;
                end else if (w_tmo) begin
                    w_nxt     = S_FIN;
                    w_set_tmo = 1'b1;
                end
            end
            S_K2:   w_nxt = S_W2;
            S_W2: begin
                if (done2) begin
                    w_nxt = S_K3;
                end else if (w_tmo) begin
                    w_nxt     = S_FIN;
                    w_set_tmo = 1'b1;
                end
            end
            S_K3:   w_nxt = S_W3;
            S_W3: begin
                // A done on the last watchdog cycle still counts as a completion.
                if (done3) begin
                    w_acc3 = 1'b1;
                    w_nxt  = (converged || (w_iter_inc == r_num)) ? S_FIN : S_K1;
                end else if (w_tmo) begin
                    w_nxt     = S_FIN;
                    w_set_tmo = 1'b1;
                end
            end
            S_FIN:  w_nxt = S_IDLE;
            default: w_nxt = S_IDLE;
        endcase
        if (abort && (r_state != S_IDLE)) begin
            w_nxt     = S_IDLE;
            w_acc3    = 1'b0;
            w_set_tmo = 1'b0;
        end
    end

    always_comb begin
        case (w_nxt)
            S_K1, S_W1: w_stage_nxt = 2'd1;
            S_K2, S_W2: w_stage_nxt = 2'd2;
            S_K3, S_W3: w_stage_nxt = 2'd3;
            default:    w_stage_nxt = 2'd0;
        endcase
    end

    // Outputs are registered from the next-state decode so they align with r_state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_wd        <= '0;
            r_num       <= '0;
            r_iter      <= '0;
            en_step1    <= 1'b0;
            en_step2    <= 1'b0;
            en_step3    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            conv_hit    <= 1'b0;
            stage       <= 2'd0;
        end else begin
            r_state  <= w_nxt;
            en_step1 <= (w_nxt == S_K1);
            en_step2 <= (w_nxt == S_K2);
            en_step3 <= (w_nxt == S_K3);
            busy     <= (w_nxt != S_IDLE);
            done     <= (w_nxt == S_FIN);
            stage    <= w_stage_nxt;

            if (w_nxt != r_state) begin
                r_wd <= '0;
            end else if (w_wait) begin
                r_wd <= r_wd + c_WD_W'(1);
            end

            if (w_take_start) begin
                r_num       <= num_iter;
                r_iter      <= '0;
                err_timeout <= 1'b0;
                conv_hit    <= 1'b0;
            end
            if (w_acc3) begin
                r_iter <= w_iter_inc;
                if (converged) conv_hit <= 1'b1;
            end
            if (w_set_tmo) err_timeout <= 1'b1;
        end
    end

endmodule
`default_nettype wire
